// File: rtl/nibble_add_sequencer.sv
// Multi-cycle WIDTH-bit add/sub using one 4-bit lookahead slice, LSB nibble first.
// Optional signed-overflow output enabled by defining ADDSEQ_OVF_EN.
module nibble_add_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef ADDSEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;

  logic             accept;
  logic             last;
  logic [3:0]       na;
  logic [3:0]       nb;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [4:0]       c;
  logic [3:0]       sum;

  assign accept = start & ((state == IDLE) | (state == DONE));
  assign last   = (state == RUN) & (idx == LAST);

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = start ? RUN : IDLE;
      RUN:     nxt = (idx == LAST) ? DONE : RUN;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // one nibble of carry-lookahead; only the carry crosses nibbles
  always_comb begin
    na   = a_q[{idx, 2'b00} +: 4];
    nb   = b_q[{idx, 2'b00} +: 4];
    p    = na ^ nb;
    g    = na & nb;
    c    = '0;
    c[0] = carry_q;
    for (int k = 0; k < 4; k++) begin
      c[k+1] = g[k] | (p[k] & c[k]);
    end
    sum  = p ^ c[3:0];
  end

  // subtract = add inverted B with carry-in of 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b ^ {WIDTH{sub}};
      carry_q <= sub;
      idx     <= '0;
      result  <= '0;
    end else if (state == RUN) begin
      result[{idx, 2'b00} +: 4] <= sum;
      carry_q <= c[4];
      if (last) begin
        carry_out <= c[4];
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef ADDSEQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (last) begin
      ovf <= c[3] ^ c[4];
    end
  end
`endif

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Directed-vector bench for nibble_add_sequencer at WIDTH=16.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_nibble_add_sequencer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef ADDSEQ_OVF_EN
  logic             ovf;
`endif

  int n_chk;
  int n_fail;

  nibble_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef ADDSEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // cycle 0 = the cycle in which start is high; returns on the done cycle
  task automatic run_op(input string tag, input logic [15:0] a,
                        input logic [15:0] b, input logic s,
                        input logic [15:0] exp_res, input logic exp_co,
                        input logic exp_ovf);
    int cyc;
    int bcnt;
    int dcyc;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    cyc   = 0;
    bcnt  = 0;
    dcyc  = -1;
    while (dcyc < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) bcnt++;
      if (done) dcyc = cyc;
    end
    check({tag, " done_cycle"}, 32'(dcyc), 32'd5);
    check({tag, " busy_cycles"}, 32'(bcnt), 32'd4);
    check({tag, " result"}, 32'(result), 32'(exp_res));
    check({tag, " carry_out"}, 32'(carry_out), 32'(exp_co));
`ifdef ADDSEQ_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unused ovf expectation");
`endif
  endtask

  initial begin
    int cyc;
    int dcyc;
    int seen;
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    sub    = 1'b0;
    op_a   = '0;
    op_b   = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst carry_out", 32'(carry_out), 32'd0);
`ifdef ADDSEQ_OVF_EN
    check("rst ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add1", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0);
    @(negedge clk);
    check("add1 done_drops", 32'(done), 32'd0);
    check("add1 result_hold", 32'(result), 32'h2201);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ok", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("no_ovf", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // start during RUN is ignored; start in DONE chains the next op
    @(negedge clk);
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    sub   = 1'b0;
    start = 1'b1;
    cyc   = 0;
    dcyc  = -1;
    while (cyc < 12) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 2) begin
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        sub   = 1'b1;
        start = 1'b1;
      end
      if (cyc == 5) begin
        check("b2b first done", 32'(done), 32'd1);
        check("b2b first result", 32'(result), 32'h3333);
        check("b2b first carry", 32'(carry_out), 32'd0);
        op_a  = 16'h00F0;
        op_b  = 16'h0F0F;
        sub   = 1'b0;
        start = 1'b1;
      end
      if (cyc == 6) check("b2b no_idle_gap", 32'(busy), 32'd1);
      if (cyc == 6) check("b2b done_drop", 32'(done), 32'd0);
      if (cyc > 5 && done && dcyc < 0) dcyc = cyc;
    end
    check("b2b second done_cycle", 32'(dcyc), 32'd10);
    check("b2b second result", 32'(result), 32'h0FFF);

    // asynchronous reset in the middle of an op
    @(negedge clk);
    op_a  = 16'hFFFF;
    op_b  = 16'h0001;
    sub   = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort result", 32'(result), 32'd0);
    check("abort carry_out", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort no_done", 32'(seen), 32'd0);
    run_op("post_rst", 16'h0123, 16'h0456, 1'b0, 16'h0579, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
